// File: rtl/cmd_queue_proc.sv
// ---------------------------------------------------------------------------
// cmd_queue_proc
// Queued command processor. Buffers up to DEPTH 16-bit commands from the UART
// wrapper and dispatches them one at a time to the calibrate / heading / move /
// solve engines. A watchdog bounds each dispatched command, and opcode 3'b111
// aborts immediately (flushes the queue and returns to IDLE).
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cmd, i_cmd_rdy    command word (opcode = cmd[15:13]) and its valid level
//   o_clr_cmd_rdy       combinational accept strobe for i_cmd
//   o_send_resp, o_resp registered response strobe and response code
//   o_strt_cal, o_in_cal, i_cal_done          calibration engine handshake
//   o_strt_hdng, o_dsrd_hdng                  heading engine start + heading
//   o_strt_mv, o_stp_lft, o_stp_rght          move engine start + stop flags
//   i_mv_cmplt          heading/move finished
//   i_sol_cmplt         maze solve finished
//   o_cmd_md            1 = command mode, 0 = solver owns the drive
//   o_q_cnt, o_q_full   queue occupancy
// ---------------------------------------------------------------------------
module cmd_queue_proc #(
  parameter int DEPTH   = 4,
  parameter int HDNG_W  = 12,
  parameter int TMO_W   = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [15:0]              i_cmd,
  input  logic                     i_cmd_rdy,
  output logic                     o_clr_cmd_rdy,
  output logic                     o_send_resp,
  output logic [7:0]               o_resp,
  output logic                     o_strt_cal,
  output logic                     o_in_cal,
  input  logic                     i_cal_done,
  output logic                     o_strt_hdng,
  output logic [HDNG_W-1:0]        o_dsrd_hdng,
  output logic                     o_strt_mv,
  output logic                     o_stp_lft,
  output logic                     o_stp_rght,
  input  logic                     i_mv_cmplt,
  input  logic                     i_sol_cmplt,
  output logic                     o_cmd_md,
  output logic [$clog2(DEPTH):0]   o_q_cnt,
  output logic                     o_q_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [TMO_W-1:0] WD_LAST  = TMO_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_CAL   = 3'b000;
  localparam logic [2:0] OP_HDNG  = 3'b001;
  localparam logic [2:0] OP_MOVE  = 3'b010;
  localparam logic [2:0] OP_SOLVE = 3'b011;
  localparam logic [2:0] OP_ABORT = 3'b111;

  localparam logic [7:0] RESP_ACK   = 8'hA5;
  localparam logic [7:0] RESP_NAK   = 8'h5A;
  localparam logic [7:0] RESP_TMO   = 8'hE1;
  localparam logic [7:0] RESP_ABORT = 8'hAB;

  typedef enum logic [2:0] {S_IDLE, S_CAL, S_HDNG, S_MOVE, S_SOLVE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [15:0]         r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_cnt;

  logic                r_send;
  logic [7:0]          r_resp;
  logic                r_strt_cal;
  logic                r_strt_hdng;
  logic                r_strt_mv;
  logic [HDNG_W-1:0]   r_hdng;
  logic                r_stp_lft;
  logic                r_stp_rght;
  logic [TMO_W-1:0]    r_wd;

  logic                w_abort;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_done;
  logic [15:0]         w_head;
  logic                w_send_nxt;
  logic [7:0]          w_resp_nxt;
  logic                w_strt_cal_nxt;
  logic                w_strt_hdng_nxt;
  logic                w_strt_mv_nxt;
  logic [HDNG_W-1:0]   w_hdng_nxt;
  logic                w_stp_lft_nxt;
  logic                w_stp_rght_nxt;
  logic [TMO_W-1:0]    w_wd_nxt;
  logic                w_unused;

  // Abort is taken in any state and is never queued, so it is accepted even
  // when the queue is full.
  assign w_abort       = i_cmd_rdy && (i_cmd[15:13] == OP_ABORT);
  assign w_full        = (r_cnt == FULL_CNT);
  assign w_push        = i_cmd_rdy && !w_abort && !w_full;
  assign o_clr_cmd_rdy = i_cmd_rdy && (w_abort || !w_full);
  assign w_head        = r_mem[r_rptr];
  assign w_unused      = ^w_head;

  // ---- command FIFO ----
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_cmd;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---- dispatch FSM: next state and next registered outputs ----
  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_done          = 1'b0;
    w_send_nxt      = 1'b0;
    w_resp_nxt      = r_resp;
    w_strt_cal_nxt  = 1'b0;
    w_strt_hdng_nxt = 1'b0;
    w_strt_mv_nxt   = 1'b0;
    w_hdng_nxt      = r_hdng;
    w_stp_lft_nxt   = r_stp_lft;
    w_stp_rght_nxt  = r_stp_rght;
    w_wd_nxt        = r_wd;

    case (r_state)
      S_IDLE: begin
        if (r_cnt != '0) begin
          w_pop    = 1'b1;
          w_wd_nxt = '0;
          case (w_head[15:13])
            OP_CAL: begin
              w_strt_cal_nxt = 1'b1;
              w_state_nxt    = S_CAL;
            end
            OP_HDNG: begin
              w_hdng_nxt      = w_head[HDNG_W-1:0];
              w_strt_hdng_nxt = 1'b1;
              w_state_nxt     = S_HDNG;
            end
            OP_MOVE: begin
              w_stp_lft_nxt  = w_head[1];
              w_stp_rght_nxt = w_head[0];
              w_strt_mv_nxt  = 1'b1;
              w_state_nxt    = S_MOVE;
            end
            OP_SOLVE: w_state_nxt = S_SOLVE;
            default: begin
              w_send_nxt = 1'b1;
              w_resp_nxt = RESP_NAK;
            end
          endcase
        end
      end
      S_CAL:          w_done = i_cal_done;
      S_HDNG, S_MOVE: w_done = i_mv_cmplt;
      S_SOLVE:        w_done = i_sol_cmplt;
      default:        w_done = 1'b0;
    endcase

    // Completion beats an expiring watchdog in the same cycle.
    if (r_state != S_IDLE) begin
      if (w_done) begin
        w_send_nxt  = 1'b1;
        w_resp_nxt  = RESP_ACK;
        w_state_nxt = S_IDLE;
      end else if (r_wd == WD_LAST) begin
        w_send_nxt  = 1'b1;
        w_resp_nxt  = RESP_TMO;
        w_state_nxt = S_IDLE;
      end else begin
        w_wd_nxt = r_wd + 1'b1;
      end
    end

    // Abort overrides everything decided above.
    if (w_abort) begin
      w_state_nxt     = S_IDLE;
      w_pop           = 1'b0;
      w_send_nxt      = 1'b1;
      w_resp_nxt      = RESP_ABORT;
      w_strt_cal_nxt  = 1'b0;
      w_strt_hdng_nxt = 1'b0;
      w_strt_mv_nxt   = 1'b0;
      w_wd_nxt        = '0;
    end
  end

  // ---- state and output registers ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_send      <= 1'b0;
      r_resp      <= '0;
      r_strt_cal  <= 1'b0;
      r_strt_hdng <= 1'b0;
      r_strt_mv   <= 1'b0;
      r_hdng      <= '0;
      r_stp_lft   <= 1'b0;
      r_stp_rght  <= 1'b0;
      r_wd        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_send      <= w_send_nxt;
      r_resp      <= w_resp_nxt;
      r_strt_cal  <= w_strt_cal_nxt;
      r_strt_hdng <= w_strt_hdng_nxt;
      r_strt_mv   <= w_strt_mv_nxt;
      r_hdng      <= w_hdng_nxt;
      r_stp_lft   <= w_stp_lft_nxt;
      r_stp_rght  <= w_stp_rght_nxt;
      r_wd        <= w_wd_nxt;
    end
  end

  assign o_send_resp = r_send;
  assign o_resp      = r_resp;
  assign o_strt_cal  = r_strt_cal;
  assign o_strt_hdng = r_strt_hdng;
  assign o_strt_mv   = r_strt_mv;
  assign o_dsrd_hdng = r_hdng;
  assign o_stp_lft   = r_stp_lft;
  assign o_stp_rght  = r_stp_rght;
  assign o_in_cal    = (r_state == S_CAL);
  assign o_cmd_md    = (r_state != S_SOLVE);
  assign o_q_cnt     = r_cnt;
  assign o_q_full    = w_full;

endmodule

// File: tb/tb_cmd_queue_proc.sv
// Directed testbench for cmd_queue_proc (DEPTH=4, TIMEOUT=16).
module tb_cmd_queue_proc;

  localparam int DEPTH  = 4;
  localparam int HDNG_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       cmd;
  logic              cmd_rdy, cal_done, mv_cmplt, sol_cmplt;
  logic              clr_cmd_rdy, send_resp, strt_cal, in_cal, strt_hdng;
  logic              strt_mv, stp_lft, stp_rght, cmd_md, q_full;
  logic [7:0]        resp;
  logic [HDNG_W-1:0] dsrd_hdng;
  logic [2:0]        q_cnt;

  int errors = 0;
  int checks = 0;

  cmd_queue_proc #(.DEPTH(DEPTH), .HDNG_W(HDNG_W), .TMO_W(8), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd(cmd), .i_cmd_rdy(cmd_rdy),
    .o_clr_cmd_rdy(clr_cmd_rdy), .o_send_resp(send_resp), .o_resp(resp),
    .o_strt_cal(strt_cal), .o_in_cal(in_cal), .i_cal_done(cal_done),
    .o_strt_hdng(strt_hdng), .o_dsrd_hdng(dsrd_hdng), .o_strt_mv(strt_mv),
    .o_stp_lft(stp_lft), .o_stp_rght(stp_rght), .i_mv_cmplt(mv_cmplt),
    .i_sol_cmplt(sol_cmplt), .o_cmd_md(cmd_md), .o_q_cnt(q_cnt), .o_q_full(q_full)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold cmd_rdy until accepted (bounded), then clock it in and drop it.
  task automatic push(input logic [15:0] c, output bit ok);
    int n;
    cmd = c;
    cmd_rdy = 1'b1;
    #1;
    n = 0;
    while (!clr_cmd_rdy && n < 40) begin
      tick();
      n++;
    end
    ok = clr_cmd_rdy;
    tick();
    cmd_rdy = 1'b0;
  endtask

  // sel: 0 strt_cal, 1 strt_hdng, 2 strt_mv, 3 send_resp. n = -1 on timeout.
  task automatic wait_for(input int sel, input int max, output int n);
    n = 0;
    while (!((sel == 0 && strt_cal) || (sel == 1 && strt_hdng) ||
             (sel == 2 && strt_mv) || (sel == 3 && send_resp)) && n < max) begin
      tick();
      n++;
    end
    if (n >= max) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (q_cnt !== 3'd0 || q_full !== 1'b0) begin errors++;
      $display("FAIL reset_q: q_cnt=%0d q_full=%b, required 0 0", q_cnt, q_full); end
    checks++; if ({send_resp, strt_cal, strt_hdng, strt_mv} !== 4'b0) begin errors++;
      $display("FAIL reset_strobes: got %b, required 0000", {send_resp, strt_cal, strt_hdng, strt_mv}); end
    checks++; if (resp !== 8'h00 || dsrd_hdng !== 12'h000 || {stp_lft, stp_rght} !== 2'b00) begin errors++;
      $display("FAIL reset_regs: resp=%h hdng=%h stp=%b, required 00 000 00", resp, dsrd_hdng, {stp_lft, stp_rght}); end
    checks++; if (cmd_md !== 1'b1 || in_cal !== 1'b0) begin errors++;
      $display("FAIL reset_mode: cmd_md=%b in_cal=%b, required 1 0", cmd_md, in_cal); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_heading();
    cmd = 16'h2123;
    cmd_rdy = 1'b1;
    #1;
    checks++; if (clr_cmd_rdy !== 1'b1) begin errors++;
      $display("FAIL hdng_clr: clr_cmd_rdy=%b, required 1", clr_cmd_rdy); end
    tick();
    cmd_rdy = 1'b0;
    checks++; if (strt_hdng !== 1'b0 || q_cnt !== 3'd1) begin errors++;
      $display("FAIL hdng_n1: strt_hdng=%b q_cnt=%0d, required 0 1", strt_hdng, q_cnt); end
    tick();
    checks++; if (strt_hdng !== 1'b1 || dsrd_hdng !== 12'h123) begin errors++;
      $display("FAIL hdng_n2: strt_hdng=%b hdng=%h, required 1 123", strt_hdng, dsrd_hdng); end
    tick();
    checks++; if (strt_hdng !== 1'b0) begin errors++;
      $display("FAIL hdng_pulse: strt_hdng=%b, required 0", strt_hdng); end
    mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin errors++;
      $display("FAIL hdng_resp: send=%b resp=%h, required 1 A5", send_resp, resp); end
    tick();
    checks++; if (send_resp !== 1'b0 || resp !== 8'hA5) begin errors++;
      $display("FAIL hdng_hold: send=%b resp=%h, required 0 A5", send_resp, resp); end
  endtask

  task automatic test_queue_full();
    logic [15:0] q [5];
    bit ok;
    int n;
    q[0] = 16'h4001; q[1] = 16'h4002; q[2] = 16'h4003; q[3] = 16'h4000; q[4] = 16'h4001;
    push(16'h4003, ok);
    tick();
    checks++; if (strt_mv !== 1'b1 || {stp_lft, stp_rght} !== 2'b11) begin errors++;
      $display("FAIL full_m0: strt_mv=%b stp=%b, required 1 11", strt_mv, {stp_lft, stp_rght}); end
    for (int i = 0; i < 4; i++) begin
      cmd = q[i];
      cmd_rdy = 1'b1;
      tick();
    end
    cmd = q[4];
    #1;
    checks++; if (q_full !== 1'b1 || q_cnt !== 3'd4 || clr_cmd_rdy !== 1'b0) begin errors++;
      $display("FAIL full_state: q_full=%b q_cnt=%0d clr=%b, required 1 4 0", q_full, q_cnt, clr_cmd_rdy); end
    tick();
    checks++; if (clr_cmd_rdy !== 1'b0 || q_cnt !== 3'd4) begin errors++;
      $display("FAIL full_hold: clr=%b q_cnt=%0d, required 0 4", clr_cmd_rdy, q_cnt); end
    mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    checks++; if (send_resp !== 1'b1 || resp !== 8'hA5 || clr_cmd_rdy !== 1'b0) begin errors++;
      $display("FAIL full_m0_done: send=%b resp=%h clr=%b, required 1 A5 0", send_resp, resp, clr_cmd_rdy); end
    tick();
    checks++; if (q_cnt !== 3'd3 || clr_cmd_rdy !== 1'b1 || strt_mv !== 1'b1 ||
                  {stp_lft, stp_rght} !== q[0][1:0]) begin errors++;
      $display("FAIL full_pop: q_cnt=%0d clr=%b strt=%b stp=%b, required 3 1 1 %b",
               q_cnt, clr_cmd_rdy, strt_mv, {stp_lft, stp_rght}, q[0][1:0]); end
    tick();
    cmd_rdy = 1'b0;
    checks++; if (q_cnt !== 3'd4) begin errors++;
      $display("FAIL full_refill: q_cnt=%0d, required 4", q_cnt); end
    mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    for (int i = 1; i < 5; i++) begin
      wait_for(2, 20, n);
      checks++; if (n < 0 || {stp_lft, stp_rght} !== q[i][1:0]) begin errors++;
        $display("FAIL full_move%0d: wait=%0d stp=%b, required strt_mv seen and stp=%b",
                 i, n, {stp_lft, stp_rght}, q[i][1:0]); end
      mv_cmplt = 1'b1;
      tick();
      mv_cmplt = 1'b0;
      checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin errors++;
        $display("FAIL full_done%0d: send=%b resp=%h, required 1 A5", i, send_resp, resp); end
    end
    checks++; if (q_cnt !== 3'd0) begin errors++;
      $display("FAIL full_drain: q_cnt=%0d, required 0", q_cnt); end
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    bit early;
    push(16'h0000, ok);
    tick();
    checks++; if (strt_cal !== 1'b1 || in_cal !== 1'b1) begin errors++;
      $display("FAIL tmo_start: strt_cal=%b in_cal=%b, required 1 1", strt_cal, in_cal); end
    early = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (send_resp) early = 1'b1;
    end
    checks++; if (early !== 1'b0 || in_cal !== 1'b1) begin errors++;
      $display("FAIL tmo_early: early_resp=%b in_cal=%b, required 0 1", early, in_cal); end
    tick();
    checks++; if (send_resp !== 1'b1 || resp !== 8'hE1 || in_cal !== 1'b0) begin errors++;
      $display("FAIL tmo_resp: send=%b resp=%h in_cal=%b, required 1 E1 0", send_resp, resp, in_cal); end
    tick();
  endtask

  task automatic test_abort();
    bit ok;
    bit any;
    push(16'h6000, ok);
    tick();
    checks++; if (cmd_md !== 1'b0) begin errors++;
      $display("FAIL abort_solve: cmd_md=%b, required 0", cmd_md); end
    push(16'h2001, ok);
    push(16'h2002, ok);
    push(16'h0000, ok);
    checks++; if (q_cnt !== 3'd3) begin errors++;
      $display("FAIL abort_q3: q_cnt=%0d, required 3", q_cnt); end
    cmd = 16'hE000;
    cmd_rdy = 1'b1;
    #1;
    checks++; if (clr_cmd_rdy !== 1'b1) begin errors++;
      $display("FAIL abort_clr: clr=%b, required 1", clr_cmd_rdy); end
    tick();
    cmd_rdy = 1'b0;
    checks++; if (q_cnt !== 3'd0 || cmd_md !== 1'b1 || send_resp !== 1'b1 || resp !== 8'hAB) begin errors++;
      $display("FAIL abort_resp: q_cnt=%0d cmd_md=%b send=%b resp=%h, required 0 1 1 AB",
               q_cnt, cmd_md, send_resp, resp); end
    any = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (strt_cal || strt_hdng || strt_mv || send_resp) any = 1'b1;
    end
    checks++; if (any !== 1'b0) begin errors++;
      $display("FAIL abort_quiet: activity=%b, required 0", any); end
  endtask

  task automatic test_nak();
    bit ok;
    push(16'h8000, ok);
    push(16'h2055, ok);
    checks++; if (send_resp !== 1'b1 || resp !== 8'h5A || q_cnt !== 3'd1) begin errors++;
      $display("FAIL nak_resp: send=%b resp=%h q_cnt=%0d, required 1 5A 1", send_resp, resp, q_cnt); end
    tick();
    checks++; if (strt_hdng !== 1'b1 || dsrd_hdng !== 12'h055 || send_resp !== 1'b0) begin errors++;
      $display("FAIL nak_next: strt_hdng=%b hdng=%h send=%b, required 1 055 0", strt_hdng, dsrd_hdng, send_resp); end
    mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin errors++;
      $display("FAIL nak_done: send=%b resp=%h, required 1 A5", send_resp, resp); end
    tick();
  endtask

  task automatic test_race_and_reset();
    bit ok;
    bit any;
    push(16'h0000, ok);
    tick();
    for (int k = 0; k < 15; k++) tick();
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin errors++;
      $display("FAIL race_resp: send=%b resp=%h, required 1 A5", send_resp, resp); end
    tick();
    checks++; if (send_resp !== 1'b0 || resp !== 8'hA5) begin errors++;
      $display("FAIL race_after: send=%b resp=%h, required 0 A5", send_resp, resp); end
    push(16'h4003, ok);
    tick();
    checks++; if (strt_mv !== 1'b1 || stp_lft !== 1'b1) begin errors++;
      $display("FAIL rst_move: strt_mv=%b stp_lft=%b, required 1 1", strt_mv, stp_lft); end
    push(16'h2001, ok);
    push(16'h2002, ok);
    checks++; if (q_cnt !== 3'd2) begin errors++;
      $display("FAIL rst_q2: q_cnt=%0d, required 2", q_cnt); end
    rst = 1'b1;
    tick();
    checks++; if ({stp_lft, stp_rght} !== 2'b00 || q_cnt !== 3'd0 || cmd_md !== 1'b1 ||
                  resp !== 8'h00 || dsrd_hdng !== 12'h000 ||
                  {send_resp, strt_cal, strt_hdng, strt_mv, in_cal} !== 5'b0) begin errors++;
      $display("FAIL rst_mid: stp=%b q_cnt=%0d cmd_md=%b resp=%h hdng=%h strobes=%b, required 00 0 1 00 000 00000",
               {stp_lft, stp_rght}, q_cnt, cmd_md, resp, dsrd_hdng,
               {send_resp, strt_cal, strt_hdng, strt_mv, in_cal}); end
    rst = 1'b0;
    any = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (strt_cal || strt_hdng || strt_mv || send_resp) any = 1'b1;
    end
    checks++; if (any !== 1'b0) begin errors++;
      $display("FAIL rst_quiet: activity=%b, required 0", any); end
  endtask

  initial begin
    rst = 1'b1;
    cmd = 16'h0000;
    cmd_rdy = 1'b0;
    cal_done = 1'b0;
    mv_cmplt = 1'b0;
    sol_cmplt = 1'b0;
    test_reset();
    test_heading();
    test_queue_full();
    test_timeout();
    test_abort();
    test_nak();
    test_race_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
